// File: rtl/zone_light_ctrl.sv
// Multi-zone occupancy lighting controller with a per-zone idle timer, warning window and timeout pulse.
// lamp/warn/off_pulse are registered; active_count is a combinational popcount of lamp.
module zone_light_ctrl #(
  parameter int NUM_ZONES = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 30000,
  parameter int WARN_T    = 3000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 all_off,
  input  logic [NUM_ZONES-1:0]                 presence,
  input  logic [NUM_ZONES-1:0]                 btn_toggle,
  output logic [NUM_ZONES-1:0]                 lamp,
  output logic [NUM_ZONES-1:0]                 warn,
  output logic [NUM_ZONES-1:0]                 off_pulse,
  output logic [$clog2(NUM_ZONES+1)-1:0]       active_count
);

  localparam int AC_W = $clog2(NUM_ZONES+1);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_WARN = 2'd2;

  localparam bit               HAS_WARN = (WARN_T > 0);
  localparam logic [CNT_W-1:0] WARN_AT  = CNT_W'(TIMEOUT - WARN_T);
  localparam logic [CNT_W-1:0] TO_AT    = CNT_W'(TIMEOUT);

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= ST_OFF;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        // Global disable and master-off both win over any per-zone activity.
        if (!enable || all_off) begin
          state <= ST_OFF;
          cnt   <= '0;
        end else begin
          case (state)
            ST_OFF: begin
              cnt <= '0;
              if (btn_toggle[z] || presence[z]) state <= ST_ON;
            end
            ST_ON: begin
              if (btn_toggle[z]) begin
                state <= ST_OFF;
                cnt   <= '0;
              end else if (presence[z]) begin
                cnt <= '0;
              end else if (HAS_WARN && cnt_inc == WARN_AT) begin
                state <= ST_WARN;
                cnt   <= cnt_inc;
              end else if (!HAS_WARN && cnt_inc == TO_AT) begin
                state <= ST_OFF;
                cnt   <= '0;
                pulse <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
            ST_WARN: begin
              // A toggle while warning extends the light instead of switching it off.
              if (btn_toggle[z] || presence[z]) begin
                state <= ST_ON;
                cnt   <= '0;
              end else if (cnt_inc == TO_AT) begin
                state <= ST_OFF;
                cnt   <= '0;
                pulse <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
            default: begin
              state <= ST_OFF;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign lamp[z]      = (state != ST_OFF);
    assign warn[z]      = (state == ST_WARN);
    assign off_pulse[z] = pulse;
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      active_count = active_count + AC_W'(lamp[i]);
    end
  end

endmodule

// File: tb/tb_zone_light_ctrl.sv
// Bench for zone_light_ctrl: table-driven timeout vectors, directed corner sequences and
// randomized traffic checked against a per-zone on/idle-age reference model.
module tb_zone_light_ctrl;
  localparam int NZ      = 4;
  localparam int TIMEOUT = 10;
  localparam int WARN_T  = 3;
  localparam int CNT_W   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          all_off;
  logic [NZ-1:0] presence;
  logic [NZ-1:0] btn_toggle;
  logic [NZ-1:0] lamp;
  logic [NZ-1:0] warn;
  logic [NZ-1:0] off_pulse;
  logic [2:0]    active_count;

  zone_light_ctrl #(
    .NUM_ZONES(NZ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WARN_T(WARN_T)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .all_off(all_off),
    .presence(presence), .btn_toggle(btn_toggle),
    .lamp(lamp), .warn(warn), .off_pulse(off_pulse), .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a zone is either dark or lit with an age in cycles since last refresh.
  bit          m_on   [NZ];
  int          m_age  [NZ];
  logic [NZ-1:0] m_pulse;

  function automatic bit m_warning(int z);
    return m_on[z] && (WARN_T > 0) && (m_age[z] >= TIMEOUT - WARN_T);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) begin
      m_on[z] = 0;
      m_age[z] = 0;
    end
    m_pulse = '0;
  endtask

  task automatic model_step(input logic en, input logic ao, input logic [NZ-1:0] p, input logic [NZ-1:0] b);
    for (int z = 0; z < NZ; z++) begin
      m_pulse[z] = 1'b0;
      if (!en || ao) begin
        m_on[z] = 0; m_age[z] = 0;
      end else if (!m_on[z]) begin
        if (p[z] || b[z]) begin m_on[z] = 1; m_age[z] = 0; end
      end else if (b[z] && !m_warning(z)) begin
        m_on[z] = 0; m_age[z] = 0;
      end else if (p[z] || b[z]) begin
        m_age[z] = 0;
      end else begin
        m_age[z]++;
        if (m_age[z] == TIMEOUT) begin
          m_on[z] = 0; m_age[z] = 0; m_pulse[z] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [NZ-1:0] el, ew;
    int cnt;
    cnt = 0;
    for (int z = 0; z < NZ; z++) begin
      el[z] = m_on[z];
      ew[z] = m_warning(z);
      cnt += int'(m_on[z]);
    end
    chk({tag, ".lamp"}, 32'(lamp), 32'(el));
    chk({tag, ".warn"}, 32'(warn), 32'(ew));
    chk({tag, ".off_pulse"}, 32'(off_pulse), 32'(m_pulse));
    chk({tag, ".active_count"}, 32'(active_count), 32'(cnt));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1 time unit later.
  task automatic cycle(input logic en, input logic ao, input logic [NZ-1:0] p, input logic [NZ-1:0] b, input string tag);
    enable = en; all_off = ao; presence = p; btn_toggle = b;
    @(posedge clk);
    model_step(en, ao, p, b);
    #1;
    chk_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, tag);
  endtask

  typedef struct {
    logic          en;
    logic          ao;
    logic [NZ-1:0] p;
    logic [NZ-1:0] b;
    logic [NZ-1:0] lamp;
    logic [NZ-1:0] warn;
    logic [NZ-1:0] pulse;
    logic [2:0]    ac;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [NZ-1:0] p, logic [NZ-1:0] l, logic [NZ-1:0] w, logic [NZ-1:0] pu, logic [2:0] ac);
    vec_t v;
    v.en = 1'b1; v.ao = 1'b0; v.p = p; v.b = '0;
    v.lamp = l; v.warn = w; v.pulse = pu; v.ac = ac;
    return v;
  endfunction

  initial begin
    // Zone 0 lit by a single presence cycle, then left idle until timeout.
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 3'd1));
    for (int i = 1; i <= 6; i++) tbl.push_back(mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 3'd1));
    for (int i = 7; i <= 9; i++) tbl.push_back(mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 3'd1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0));

    rst = 1'b1; enable = 1'b1; all_off = 1'b0; presence = '0; btn_toggle = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset_hold");
    rst = 1'b0;

    // Asynchronous reset mid-cycle with two zones lit.
    cycle(1'b1, 1'b0, 4'b0011, 4'b0000, "pre_rst");
    idle(7, "pre_rst_idle");
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst.lamp", 32'(lamp), 32'd0);
    chk("async_rst.warn", 32'(warn), 32'd0);
    chk("async_rst.count", 32'(active_count), 32'd0);
    @(posedge clk);
    #1;
    chk("async_rst.pulse", 32'(off_pulse), 32'd0);
    rst = 1'b0;
    idle(20, "post_rst_idle");

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].ao, tbl[i].p, tbl[i].b, "tbl");
      chk($sformatf("tbl[%0d].lamp", i), 32'(lamp), 32'(tbl[i].lamp));
      chk($sformatf("tbl[%0d].warn", i), 32'(warn), 32'(tbl[i].warn));
      chk($sformatf("tbl[%0d].pulse", i), 32'(off_pulse), 32'(tbl[i].pulse));
      chk($sformatf("tbl[%0d].count", i), 32'(active_count), 32'(tbl[i].ac));
    end

    // Presence during WARN restarts the full timeout.
    cycle(1'b1, 1'b0, 4'b0001, 4'b0000, "t3_on");
    idle(8, "t3_idle");
    chk("t3.in_warn", 32'(warn[0]), 32'd1);
    cycle(1'b1, 1'b0, 4'b0001, 4'b0000, "t3_refresh");
    chk("t3.warn_cleared", 32'(warn[0]), 32'd0);
    chk("t3.lamp_kept", 32'(lamp[0]), 32'd1);
    for (int i = 0; i < 9; i++) begin
      idle(1, "t3_wait");
      chk("t3.no_early_pulse", 32'(off_pulse[0]), 32'd0);
      chk("t3.still_lit", 32'(lamp[0]), 32'd1);
    end
    idle(1, "t3_expire");
    chk("t3.pulse", 32'(off_pulse[0]), 32'd1);
    chk("t3.lamp_off", 32'(lamp[0]), 32'd0);

    // Manual toggles on zone 1.
    cycle(1'b1, 1'b0, '0, 4'b0010, "t4_on");
    chk("t4.on", 32'(lamp[1]), 32'd1);
    idle(4, "t4_idle4");
    cycle(1'b1, 1'b0, '0, 4'b0010, "t4_off");
    chk("t4.manual_off", 32'(lamp[1]), 32'd0);
    chk("t4.no_pulse", 32'(off_pulse[1]), 32'd0);
    cycle(1'b1, 1'b0, '0, 4'b0010, "t4_on2");
    idle(7, "t4_to_warn");
    chk("t4.warn", 32'(warn[1]), 32'd1);
    cycle(1'b1, 1'b0, '0, 4'b0010, "t4_extend");
    chk("t4.extend_lamp", 32'(lamp[1]), 32'd1);
    chk("t4.extend_warn", 32'(warn[1]), 32'd0);
    idle(6, "t4_recount");
    chk("t4.cnt_restart_nowarn", 32'(warn[1]), 32'd0);
    idle(1, "t4_rewarn");
    chk("t4.cnt_restart_warn", 32'(warn[1]), 32'd1);

    // all_off beats same-cycle presence.
    cycle(1'b1, 1'b0, '0, 4'b0100, "t5_z2_on");
    chk("t5.two_lit", 32'(lamp), 32'b0110);
    cycle(1'b1, 1'b1, 4'b1010, '0, "t5_alloff");
    chk("t5.all_dark", 32'(lamp), 32'd0);
    chk("t5.no_pulse", 32'(off_pulse), 32'd0);
    cycle(1'b1, 1'b0, 4'b1000, '0, "t5_z3");
    chk("t5.z3_on", 32'(lamp), 32'b1000);

    // enable low overrides a zone in WARN and ignores presence.
    cycle(1'b1, 1'b0, 4'b0100, '0, "t6_z2_on");
    idle(7, "t6_to_warn");
    chk("t6.warn", 32'(warn[2]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 4'b0100, '0, "t6_dis");
      chk("t6.lamp_off", 32'(lamp[2]), 32'd0);
      chk("t6.warn_off", 32'(warn[2]), 32'd0);
      chk("t6.no_pulse", 32'(off_pulse), 32'd0);
    end
    cycle(1'b1, 1'b0, 4'b0100, '0, "t6_reen");
    chk("t6.relit", 32'(lamp[2]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic en, ao;
      logic [NZ-1:0] p, b;
      en = ($urandom_range(0, 49) != 0);
      ao = ($urandom_range(0, 59) == 0);
      for (int z = 0; z < NZ; z++) begin
        p[z] = ($urandom_range(0, 11) == 0);
        b[z] = ($urandom_range(0, 19) == 0);
      end
      cycle(en, ao, p, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zone_light_ctrl.md
Name: zone_light_ctrl

Overview:
- Multi-zone automatic lighting controller. Generalises the single-channel occupancy shutdown timer to NUM_ZONES independent zones.
- Each zone has its own occupancy input, manual toggle pulse, idle timer, pre-shutdown warning window and one-cycle shutdown pulse.
- Sits between the synchronised sensor/button front-end and the lamp drivers and status panel.

Parameters:
- NUM_ZONES, 4: number of independent zones (>=1).
- CNT_W, 16: idle-counter width. Must satisfy 2^CNT_W > TIMEOUT.
- TIMEOUT, 30000: idle cycles from the last presence/turn-on until the zone switches off (>=2).
- WARN_T, 3000: length of the warning window at the end of TIMEOUT (0 <= WARN_T < TIMEOUT). When 0, the WARN state is never entered.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global enable. Low forces every zone OFF.
- all_off  in  1  one-cycle master-off request.
- presence  in  NUM_ZONES  per-zone occupancy, 1 = occupied, already synchronised.
- btn_toggle  in  NUM_ZONES  per-zone manual toggle, one-cycle pulses, already debounced.
- lamp  out  NUM_ZONES  per-zone lamp drive, 1 = on.
- warn  out  NUM_ZONES  per-zone warning indicator (zone in WARN).
- off_pulse  out  NUM_ZONES  one-cycle pulse when a zone switches off by timeout.
- active_count  out  $clog2(NUM_ZONES+1)  number of zones with lamp=1.

Behaviour:
- Reset, clk and rst: reset rst, asynchronous, active-high; clock clk. Reset puts every zone in OFF with counter=0; lamp, warn, off_pulse and active_count = 0. Reset mid-operation aborts all timers immediately and produces no off_pulse.
- Per-zone FSM: states OFF, ON, WARN, plus an idle counter cnt[CNT_W].
  - lamp = (state != OFF).
  - warn = (state == WARN).
  - Both are decoded from registered state.
  - active_count = combinational popcount of lamp.
- Per-zone priority for each clock edge, highest first:
  1. rst.
  2. enable=0: zone goes to OFF, cnt=0, presence and buttons ignored, no off_pulse.
  3. all_off=1: zone goes to OFF, cnt=0, no off_pulse. presence and btn_toggle in the same cycle are ignored.
  4. btn_toggle.
  5. presence.
  6. Timer.
- OFF:
  - btn_toggle or presence -> ON, cnt=0.
  - Otherwise stay; cnt holds 0.
- ON:
  - btn_toggle -> OFF, cnt=0, no off_pulse (manual off).
  - Else presence -> stay ON, cnt=0.
  - Else cnt <= cnt+1.
  - If cnt+1 == TIMEOUT-WARN_T and WARN_T>0 -> WARN.
  - If cnt+1 == TIMEOUT and WARN_T==0 -> OFF, cnt=0, off_pulse.
- WARN:
  - btn_toggle or presence -> ON, cnt=0. A toggle during warning extends the light; it does not switch it off.
  - Else cnt <= cnt+1. If cnt+1 == TIMEOUT -> OFF, cnt=0, off_pulse.
- Timing:
  - Zone enters ON at edge k and presence stays low: WARN at edge k+TIMEOUT-WARN_T, OFF at edge k+TIMEOUT.
  - off_pulse is registered and high for exactly the one cycle after the switching edge, coincident with lamp=0.
  - presence held high keeps cnt at 0 indefinitely.
- Zones are fully independent. Simultaneous events on different zones are each handled by their own FSM in the same cycle.
- Defensive: an illegal state encoding returns to OFF with cnt=0.

Test Plan:
Bench parameters: NUM_ZONES=4, TIMEOUT=10, WARN_T=3, CNT_W=8.
1. rst pulse asserted asynchronously mid-cycle -> all outputs 0 immediately. After release with no stimulus, outputs stay 0 for 20 cycles.
2. presence[0]=1 for one cycle then 0 -> lamp[0]=1 and active_count=1 after that edge; warn[0]=1 from edge +7; at edge +10 lamp[0]=0, warn[0]=0, off_pulse[0]=1 for exactly 1 cycle, active_count=0.
3. Zone 0 in WARN (edge +8), presence[0]=1 for one cycle -> warn[0]=0 next edge, lamp stays 1. Full 10-cycle timeout restarts from that edge, and there is no off_pulse before it expires.
4. Manual toggle sequence on zone 1:
   - btn_toggle[1] in OFF -> ON.
   - btn_toggle[1] at idle count 4 -> OFF with off_pulse[1]=0.
   - Turn on again, then btn_toggle[1] during WARN -> back to ON with cnt=0.
5. Zones 1 and 2 ON; all_off=1 in the same cycle as presence[1]=1 and presence[3]=1 -> all lamps 0 next edge, no off_pulse, zone 3 stays OFF. One cycle later, presence[3]=1 -> lamp[3]=1.
6. Zone 2 in WARN, then enable=0 for 5 cycles with presence[2]=1 -> lamp[2]=warn[2]=0 next edge, no off_pulse, presence ignored. When enable returns with presence[2]=1 -> lamp[2]=1 next edge.
